// File: rtl/freq_gen_pkg.sv
// Shared definitions for the multi-channel frequency generator: default
// divisor, default divisor width, channel-select width helper and the
// per-channel configuration record.
package freq_gen_pkg;

  // Divisor width used when the instantiating level does not override it
  localparam int DIV_W_DEF = 24;

  // Half-period minus one for 1 kHz from a 100 MHz clock (50000 cycles high, 50000 low)
  localparam int DEFAULT_DIV_DEF = 49999;

  // Channel-select width; a single-channel build still needs a one-bit select
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // One configuration write as seen by a channel: enable plus half-period divisor
  typedef struct packed {
    logic                 en;
    logic [DIV_W_DEF-1:0] div;
  } chan_cfg_t;

endpackage

// File: rtl/freq_gen_chan.sv
// One generator channel: half-period counter, active and pending divisor,
// enable flag, and the registered square-wave and tick outputs. A divisor
// written while running is held pending and swapped in only at a half-period
// boundary, so the output never shows a runt or stretched half-period.
module freq_gen_chan
  import freq_gen_pkg::*;
#(
  parameter int             DIV_W       = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(DEFAULT_DIV_DEF),
  parameter logic           RST_EN      = 1'b1
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick
);

  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] act_div, act_div_nxt;
  logic [DIV_W-1:0] pend_div, pend_div_nxt;
  logic             pend_vld, pend_vld_nxt;
  logic             en, en_nxt;
  logic             clk_out_nxt;
  logic             tick_nxt;

  // Next state: free-running count first, then a configuration write, then
  // the phase-restart; later stages override earlier ones
  always_comb begin
    cnt_nxt      = cnt;
    act_div_nxt  = act_div;
    pend_div_nxt = pend_div;
    pend_vld_nxt = pend_vld;
    en_nxt       = en;
    clk_out_nxt  = clk_out;
    tick_nxt     = 1'b0;

    if (en) begin
      if (cnt == act_div) begin
        cnt_nxt     = '0;
        clk_out_nxt = ~clk_out;
        tick_nxt    = 1'b1;
        if (pend_vld) begin
          act_div_nxt  = pend_div;
          pend_vld_nxt = 1'b0;
        end
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end

    if (wr) begin
      if (!wr_en) begin
        en_nxt       = 1'b0;
        cnt_nxt      = '0;
        clk_out_nxt  = 1'b0;
        tick_nxt     = 1'b0;
        act_div_nxt  = wr_div;
        pend_vld_nxt = 1'b0;
      end else if (en && !sync) begin
        pend_div_nxt = wr_div;
        pend_vld_nxt = 1'b1;
      end else begin
        en_nxt       = 1'b1;
        cnt_nxt      = '0;
        clk_out_nxt  = 1'b0;
        tick_nxt     = 1'b0;
        act_div_nxt  = wr_div;
        pend_vld_nxt = 1'b0;
      end
    end

    if (sync && en_nxt) begin
      cnt_nxt     = '0;
      clk_out_nxt = 1'b0;
      tick_nxt    = 1'b0;
      if (pend_vld_nxt) begin
        act_div_nxt  = pend_div_nxt;
        pend_vld_nxt = 1'b0;
      end
    end
  end

  // Channel state register with synchronous active-low reset
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      cnt      <= '0;
      act_div  <= DEFAULT_DIV;
      pend_div <= '0;
      pend_vld <= 1'b0;
      en       <= RST_EN;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      act_div  <= act_div_nxt;
      pend_div <= pend_div_nxt;
      pend_vld <= pend_vld_nxt;
      en       <= en_nxt;
      clk_out  <= clk_out_nxt;
      tick     <= tick_nxt;
    end
  end

endmodule

// File: rtl/freq_gen_multi.sv
// Multi-channel square-wave/tick generator for valve and pump timing. Decodes
// configuration writes to one channel, flags writes to non-existent channels,
// and broadcasts the phase-restart pulse to every channel.
module freq_gen_multi
  import freq_gen_pkg::*;
#(
  parameter int                NUM_CH      = 4,
  parameter int                DIV_W       = DIV_W_DEF,
  parameter logic [DIV_W-1:0]  DEFAULT_DIV = DIV_W'(DEFAULT_DIV_DEF),
  parameter logic [NUM_CH-1:0] RST_EN      = '1,
  localparam int               CH_W        = ch_width(NUM_CH)
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_en,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              sync_all,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic              cfg_err
);

  logic [NUM_CH-1:0] wr_sel;
  logic              cfg_bad;

  // Out-of-range selects exist only when NUM_CH does not fill the select space
  generate
    if ((1 << CH_W) > NUM_CH) begin : g_range_chk
      assign cfg_bad = (cfg_ch >= CH_W'(NUM_CH));
    end else begin : g_range_full
      assign cfg_bad = 1'b0;
    end
  endgenerate

  // Error strobe is registered so the block has no input-to-output path
  always_ff @(posedge clk_100m) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && cfg_bad;
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      assign wr_sel[i] = cfg_we && (cfg_ch == CH_W'(i));

      freq_gen_chan #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .RST_EN      (RST_EN[i])
      ) u_chan (
        .clk_100m (clk_100m),
        .rst_n    (rst_n),
        .wr       (wr_sel[i]),
        .wr_en    (cfg_en),
        .wr_div   (cfg_div),
        .sync     (sync_all),
        .clk_out  (clk_out[i]),
        .tick     (tick[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_freq_gen_multi.sv
// Directed bench for freq_gen_multi built with three channels so that
// channel select 3 is out of range. Inputs change on the falling edge and
// outputs are sampled on the falling edge; expected values are hand-derived
// edge counts relative to each write or reset release.
module tb_freq_gen_multi;
  import freq_gen_pkg::*;

  localparam int NUM_CH = 3;

  logic              clk_100m = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic              cfg_en;
  logic [23:0]       cfg_div;
  logic              sync_all;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic              cfg_err;

  int checks   = 0;
  int failures = 0;

  freq_gen_multi #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (24),
    .DEFAULT_DIV (24'd49999),
    .RST_EN      (3'b111)
  ) dut (
    .clk_100m (clk_100m),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_en   (cfg_en),
    .cfg_div  (cfg_div),
    .sync_all (sync_all),
    .clk_out  (clk_out),
    .tick     (tick),
    .cfg_err  (cfg_err)
  );

  // 100 MHz system clock
  always #5 clk_100m = ~clk_100m;

  // One comparison: counted, and reported with tag/observed/expected on failure
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Single configuration write; returns at the falling edge after the
  // rising edge that sampled it
  task automatic applyStimulus(input logic [1:0] ch, input chan_cfg_t cfg);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_en  = cfg.en;
    cfg_div = cfg.div;
    @(negedge clk_100m);
    cfg_we  = 1'b0;
  endtask

  // Directed sequence: reset defaults, retune, disable/re-enable, double
  // write at terminal count, sync_all, bad channel, mid-run reset
  initial begin
    logic seen_activity;
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_en   = 1'b0;
    cfg_div  = '0;
    sync_all = 1'b0;
    $display("[TB] start");

    repeat (3) @(negedge clk_100m);
    checkOutput("rst_clk_out", 32'(clk_out), 32'd0);
    checkOutput("rst_tick", 32'(tick), 32'd0);
    checkOutput("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;

    repeat (100) @(negedge clk_100m);
    applyStimulus(2'd1, '{en: 1'b1, div: 24'd9});
    repeat (49898) @(negedge clk_100m);
    checkOutput("dflt_e49999_clk", 32'(clk_out), 32'd0);
    checkOutput("dflt_e49999_tick", 32'(tick), 32'd0);
    @(negedge clk_100m);
    checkOutput("dflt_e50000_clk", 32'(clk_out), 32'b111);
    checkOutput("dflt_e50000_tick", 32'(tick), 32'b111);
    @(negedge clk_100m);
    checkOutput("dflt_e50001_tick", 32'(tick), 32'd0);
    checkOutput("dflt_e50001_clk", 32'(clk_out), 32'b111);
    repeat (8) @(negedge clk_100m);
    checkOutput("retune_e50009_clk", 32'(clk_out), 32'b111);
    @(negedge clk_100m);
    checkOutput("retune_e50010_clk", 32'(clk_out), 32'b101);
    checkOutput("retune_e50010_tick", 32'(tick), 32'b010);
    repeat (10) @(negedge clk_100m);
    checkOutput("retune_e50020_clk", 32'(clk_out), 32'b111);
    checkOutput("retune_e50020_tick", 32'(tick), 32'b010);

    applyStimulus(2'd2, '{en: 1'b0, div: 24'd0});
    checkOutput("dis_ch2_clk", 32'(clk_out), 32'b011);
    checkOutput("dis_ch2_tick", 32'(tick), 32'd0);
    repeat (5) @(negedge clk_100m);
    checkOutput("dis_ch2_hold_clk", 32'(clk_out), 32'b011);
    checkOutput("dis_ch2_hold_tick", 32'(tick), 32'd0);
    applyStimulus(2'd2, '{en: 1'b1, div: 24'd0});
    checkOutput("en_ch2_k_clk", 32'(clk_out), 32'b011);
    @(negedge clk_100m);
    checkOutput("en_ch2_k1_clk", 32'(clk_out), 32'b111);
    checkOutput("en_ch2_k1_tick", 32'(tick), 32'b100);
    @(negedge clk_100m);
    checkOutput("en_ch2_k2_clk", 32'(clk_out), 32'b011);
    checkOutput("en_ch2_k2_tick", 32'(tick), 32'b100);
    @(negedge clk_100m);
    checkOutput("en_ch2_k3_clk", 32'(clk_out), 32'b101);
    checkOutput("en_ch2_k3_tick", 32'(tick), 32'b110);

    applyStimulus(2'd0, '{en: 1'b0, div: 24'd9});
    applyStimulus(2'd0, '{en: 1'b1, div: 24'd9});
    checkOutput("pend_k_clk0", 32'(clk_out[0]), 32'd0);
    repeat (2) @(negedge clk_100m);
    applyStimulus(2'd0, '{en: 1'b1, div: 24'd4});
    repeat (6) @(negedge clk_100m);
    applyStimulus(2'd0, '{en: 1'b1, div: 24'd7});
    checkOutput("pend_k10_clk0", 32'(clk_out[0]), 32'd1);
    checkOutput("pend_k10_tick0", 32'(tick[0]), 32'd1);
    repeat (4) @(negedge clk_100m);
    checkOutput("pend_k14_tick0", 32'(tick[0]), 32'd0);
    @(negedge clk_100m);
    checkOutput("pend_k15_clk0", 32'(clk_out[0]), 32'd0);
    checkOutput("pend_k15_tick0", 32'(tick[0]), 32'd1);
    repeat (7) @(negedge clk_100m);
    checkOutput("pend_k22_tick0", 32'(tick[0]), 32'd0);
    @(negedge clk_100m);
    checkOutput("pend_k23_clk0", 32'(clk_out[0]), 32'd1);
    checkOutput("pend_k23_tick0", 32'(tick[0]), 32'd1);
    repeat (8) @(negedge clk_100m);
    checkOutput("pend_k31_clk0", 32'(clk_out[0]), 32'd0);
    checkOutput("pend_k31_tick0", 32'(tick[0]), 32'd1);

    applyStimulus(2'd0, '{en: 1'b1, div: 24'd3});
    applyStimulus(2'd1, '{en: 1'b1, div: 24'd5});
    applyStimulus(2'd2, '{en: 1'b1, div: 24'd7});
    sync_all = 1'b1;
    @(negedge clk_100m);
    sync_all = 1'b0;
    checkOutput("sync_s_clk", 32'(clk_out), 32'd0);
    checkOutput("sync_s_tick", 32'(tick), 32'd0);
    repeat (3) @(negedge clk_100m);
    checkOutput("sync_s3_tick", 32'(tick), 32'd0);
    @(negedge clk_100m);
    checkOutput("sync_s4_clk", 32'(clk_out), 32'b001);
    checkOutput("sync_s4_tick", 32'(tick), 32'b001);
    @(negedge clk_100m);
    checkOutput("sync_s5_tick", 32'(tick), 32'd0);
    @(negedge clk_100m);
    checkOutput("sync_s6_clk", 32'(clk_out), 32'b011);
    checkOutput("sync_s6_tick", 32'(tick), 32'b010);
    repeat (2) @(negedge clk_100m);
    checkOutput("sync_s8_clk", 32'(clk_out), 32'b110);
    checkOutput("sync_s8_tick", 32'(tick), 32'b101);

    applyStimulus(2'd3, '{en: 1'b0, div: 24'd0});
    checkOutput("bad_ch_err", 32'(cfg_err), 32'd1);
    checkOutput("bad_ch_clk", 32'(clk_out), 32'b110);
    @(negedge clk_100m);
    checkOutput("bad_ch_err_clear", 32'(cfg_err), 32'd0);
    repeat (2) @(negedge clk_100m);
    checkOutput("bad_ch_s12_clk", 32'(clk_out), 32'b101);
    checkOutput("bad_ch_s12_tick", 32'(tick), 32'b011);

    applyStimulus(2'd0, '{en: 1'b1, div: 24'd1});
    applyStimulus(2'd1, '{en: 1'b1, div: 24'd2});
    rst_n = 1'b0;
    @(negedge clk_100m);
    checkOutput("rst2_clk", 32'(clk_out), 32'd0);
    checkOutput("rst2_tick", 32'(tick), 32'd0);
    checkOutput("rst2_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    seen_activity = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_100m);
      seen_activity = seen_activity | (|clk_out) | (|tick);
    end
    checkOutput("rst2_no_early_toggle", 32'(seen_activity), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
